dpsk_tx: RTL and testbench

- DPSK transmitter: the modulating end of the 50 kHz DPSK link whose receive side runs the DPLL/DCO bit-clock recovery.
- Accepts bytes over a valid/ready handshake and sends a preamble of ones so the far-end DPLL can lock.
- Differentially encodes each bit LSB-first and outputs a 1-bit square-wave carrier whose phase flips 180° at a symbol boundary for every '1' bit.
- Sits between the frame/packet logic and the analog output driver/filter.

---
 rtl/dpsk_tx_if.sv | 20 ++
 rtl/dpsk_tx.sv | 173 +++++++++++++++++
 tb/tb_dpsk_tx.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dpsk_tx_if.sv
// Byte handshake between the frame/packet logic and the DPSK transmitter.
interface dpsk_tx_if;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;

    // Packet logic side: offers bytes
    modport master (
        output tx_byte,
        output tx_valid,
        input  tx_ready
    );

    // Transmitter side: accepts bytes
    modport slave (
        input  tx_byte,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/dpsk_tx.sv
// DPSK transmitter: preamble of ones, then LSB-first differentially encoded
// bytes on a square carrier that inverts at a symbol start for every '1'.
module dpsk_tx #(
    parameter int unsigned CARRIER_DIV    = 20,
    parameter int unsigned CYCLES_PER_BIT = 4,
    parameter int unsigned PREAMBLE_BITS  = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    dpsk_tx_if.slave       tx_if,
    output logic           carrier_out,
    output logic           sym_tick,
    output logic           busy,
    output logic           frame_done
);

    localparam int unsigned CNT_W = $clog2(CARRIER_DIV);
    localparam int unsigned CYC_W = $clog2(CYCLES_PER_BIT) + 1;
    localparam int unsigned PRE_W = $clog2(PREAMBLE_BITS) + 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT     = 2'd1,
        S_PREAMBLE = 2'd2,
        S_DATA     = 2'd3
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [PRE_W-1:0]   pre_cnt_q;
    logic [2:0]         bit_idx_q;
    logic [7:0]         shift_q;
    logic [7:0]         next_buf_q;
    logic               pending_q;
    logic               phase_q, phase_d;
    logic               carrier_q, carrier_d;
    logic               sym_tick_q;
    logic               busy_q;
    logic               frame_done_q;

    logic               cnt_wrap;
    logic               cyc_last;
    logic               tick;
    logic               tx_ready_c;
    logic               xfer;
    logic               sym_bit;
    logic               last_bit;

    // Free-running carrier/symbol timing chain
    always_comb begin
        cnt_wrap = (cnt_q == CNT_W'(CARRIER_DIV - 1));
        cyc_last = (cyc_q == CYC_W'(CYCLES_PER_BIT - 1));
        tick     = cnt_wrap && cyc_last;
        cnt_d    = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
        cyc_d    = cyc_q;
        if (cnt_wrap) begin
            cyc_d = cyc_last ? '0 : cyc_q + CYC_W'(1);
        end
    end

    // Handshake: ready in IDLE, or during the final data bit with no byte queued
    always_comb begin
        last_bit   = (bit_idx_q == 3'd7);
        tx_ready_c = (state_q == S_IDLE) ||
                     ((state_q == S_DATA) && last_bit && !pending_q);
        xfer       = tx_if.tx_valid && tx_ready_c;
    end

    assign tx_if.tx_ready = tx_ready_c;

    // Bit carried by the symbol that starts after the current sym_tick
    always_comb begin
        sym_bit = 1'b0;
        case (state_q)
            S_WAIT:     sym_bit = 1'b1;
            S_PREAMBLE: sym_bit = (pre_cnt_q == PRE_W'(PREAMBLE_BITS - 1)) ? shift_q[0] : 1'b1;
            S_DATA: begin
                if (!last_bit) begin
                    sym_bit = shift_q[1];
                end else if (pending_q) begin
                    sym_bit = next_buf_q[0];
                end else if (xfer) begin
                    sym_bit = tx_if.tx_byte[0];
                end
            end
            default:    sym_bit = 1'b0;
        endcase
        phase_d   = phase_q ^ (tick & sym_bit);
        carrier_d = (cnt_d < CNT_W'(CARRIER_DIV / 2)) ^ phase_d;
    end

    // Timing chain, carrier and framing FSM registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            cyc_q        <= '0;
            pre_cnt_q    <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            next_buf_q   <= '0;
            pending_q    <= 1'b0;
            phase_q      <= 1'b0;
            carrier_q    <= 1'b1;
            sym_tick_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            cyc_q        <= cyc_d;
            phase_q      <= phase_d;
            carrier_q    <= carrier_d;
            sym_tick_q   <= (cnt_d == CNT_W'(CARRIER_DIV - 1)) &&
                            (cyc_d == CYC_W'(CYCLES_PER_BIT - 1));
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (xfer) begin
                        shift_q <= tx_if.tx_byte;
                        busy_q  <= 1'b1;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (tick) begin
                        pre_cnt_q <= '0;
                        state_q   <= S_PREAMBLE;
                    end
                end
                S_PREAMBLE: begin
                    if (tick) begin
                        if (pre_cnt_q == PRE_W'(PREAMBLE_BITS - 1)) begin
                            bit_idx_q <= '0;
                            state_q   <= S_DATA;
                        end else begin
                            pre_cnt_q <= pre_cnt_q + PRE_W'(1);
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        if (!last_bit) begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            shift_q   <= shift_q >> 1;
                        end else if (pending_q) begin
                            shift_q   <= next_buf_q;
                            bit_idx_q <= '0;
                            pending_q <= 1'b0;
                        end else if (xfer) begin
                            shift_q   <= tx_if.tx_byte;
                            bit_idx_q <= '0;
                        end else begin
                            busy_q       <= 1'b0;
                            frame_done_q <= 1'b1;
                            state_q      <= S_IDLE;
                        end
                    end else if (xfer) begin
                        next_buf_q <= tx_if.tx_byte;
                        pending_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign carrier_out = carrier_q;
    assign sym_tick    = sym_tick_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_dpsk_tx.sv
// Directed bench for dpsk_tx with a 20-clk carrier, 4 carrier periods per
// symbol (80 clk) and an 8-symbol preamble.
module tb_dpsk_tx;

    localparam int DIV = 20;
    localparam int CPB = 4;
    localparam int PRE = 8;
    localparam int SYM = DIV * CPB;

    logic clk;
    logic rst_n;
    logic carrier_out;
    logic sym_tick;
    logic busy;
    logic frame_done;

    int   n_chk;
    int   n_pass;
    int   t;
    bit   ph;

    dpsk_tx_if tx_if ();

    dpsk_tx #(
        .CARRIER_DIV    (DIV),
        .CYCLES_PER_BIT (CPB),
        .PREAMBLE_BITS  (PRE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_if       (tx_if),
        .carrier_out (carrier_out),
        .sym_tick    (sym_tick),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clocks since reset release: mirrors the carrier counter position
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) t <= 0;
        else        t <= t + 1;
    end

    task automatic test_reset();
        logic [4:0] got;
        rst_n = 1'b0;
        tx_if.tx_valid = 1'b0;
        tx_if.tx_byte  = 8'h00;
        repeat (3) @(negedge clk);
        got = {carrier_out, sym_tick, busy, frame_done, tx_if.tx_ready};
        n_chk++;
        if (got !== 5'b10001)
            $display("FAIL reset_values got=%b exp=10001", got);
        else
            n_pass++;
    endtask

    task automatic test_idle();
        logic [3:0] got, exp;
        rst_n = 1'b1;
        for (int i = 0; i < 400; i++) begin
            exp = {((i % DIV) < DIV / 2) ? 1'b1 : 1'b0, ((i % SYM) == SYM - 1) ? 1'b1 : 1'b0, 1'b0, 1'b1};
            got = {carrier_out, sym_tick, busy, tx_if.tx_ready};
            n_chk++;
            if (got !== exp)
                $display("FAIL idle_carrier cyc=%0d got=%b exp=%b", i, got, exp);
            else
                n_pass++;
            @(negedge clk);
        end
    endtask

    // Sends one byte, or two bytes with tx_valid held high, and checks the
    // carrier, sym_tick, busy and frame_done every clock of the frame.
    task automatic test_frame(input string name, input int nbytes,
                              input logic [7:0] b0, input logic [7:0] b1);
        logic [7:0] bytes [2];
        bit         syms [$];
        int         nsym, ticks, nx, since_end, end_tick;
        int         xfer_at [2];
        bit         go_next, exp_tick, exp_busy, exp_done, exp_car;
        logic [3:0] got, exp;
        bytes[0] = b0;
        bytes[1] = b1;
        for (int i = 0; i < PRE; i++) syms.push_back(1'b1);
        for (int bi = 0; bi < nbytes; bi++)
            for (int k = 0; k < 8; k++) syms.push_back(bytes[bi][k]);
        nsym      = syms.size();
        end_tick  = nsym + 1;
        ticks     = 0;
        nx        = 0;
        since_end = -1;
        xfer_at[0] = -1;
        xfer_at[1] = -1;
        while ((t % SYM) != 10) @(negedge clk);
        tx_if.tx_byte  = b0;
        tx_if.tx_valid = 1'b1;
        for (int c = 0; c < SYM * (nsym + 3); c++) begin
            exp_tick = ((t % SYM) == SYM - 1);
            exp_busy = (nx > 0) && (ticks < end_tick);
            exp_done = (since_end == 0);
            exp_car  = (((t % DIV) < DIV / 2) ? 1'b1 : 1'b0) ^ ph;
            exp = {exp_car, exp_tick, exp_busy, exp_done};
            got = {carrier_out, sym_tick, busy, frame_done};
            n_chk++;
            if (got !== exp)
                $display("FAIL frame_%s cyc=%0d sym=%0d got=%b exp=%b", name, c, ticks, got, exp);
            else
                n_pass++;
            go_next = tx_if.tx_valid && tx_if.tx_ready;
            if (go_next && nx < 2) xfer_at[nx] = ticks;
            if (since_end >= 0) since_end++;
            if (exp_tick) begin
                ticks++;
                if (ticks - 1 < nsym) ph ^= syms[ticks - 1];
                if (ticks == end_tick) since_end = 0;
            end
            @(negedge clk);
            if (go_next) begin
                nx++;
                if (nx < nbytes) begin
                    tx_if.tx_byte = bytes[nx];
                end else begin
                    tx_if.tx_valid = 1'b0;
                    tx_if.tx_byte  = 8'h00;
                end
            end
            if (since_end == 3) break;
        end
        n_chk++;
        if (since_end != 3)
            $display("FAIL frame_%s_end_timeout since_end=%0d exp=3", name, since_end);
        else
            n_pass++;
        n_chk++;
        if (nx != nbytes)
            $display("FAIL frame_%s_transfers got=%0d exp=%0d", name, nx, nbytes);
        else
            n_pass++;
        if (nbytes == 2) begin
            n_chk++;
            if (xfer_at[1] != PRE + 8)
                $display("FAIL frame_%s_second_xfer_symbol got=%0d exp=%0d", name, xfer_at[1], PRE + 8);
            else
                n_pass++;
        end
        n_chk++;
        if (tx_if.tx_ready !== 1'b1)
            $display("FAIL frame_%s_ready_after got=%b exp=1", name, tx_if.tx_ready);
        else
            n_pass++;
    endtask

    // Transfer in the sym_tick cycle while IDLE: one idle symbol, then preamble
    task automatic test_xfer_on_tick();
        int found;
        while ((t % SYM) != SYM - 1) @(negedge clk);
        n_chk++;
        if (sym_tick !== 1'b1)
            $display("FAIL tick_xfer_tick got=%b exp=1", sym_tick);
        else
            n_pass++;
        tx_if.tx_byte  = 8'h00;
        tx_if.tx_valid = 1'b1;
        @(negedge clk);
        tx_if.tx_valid = 1'b0;
        n_chk++;
        if ({busy, carrier_out} !== {1'b1, ~ph})
            $display("FAIL tick_xfer_no_flip got=%b exp=%b", {busy, carrier_out}, {1'b1, ~ph});
        else
            n_pass++;
        repeat (SYM - 1) @(negedge clk);
        n_chk++;
        if ({sym_tick, busy, carrier_out} !== {2'b11, ph})
            $display("FAIL tick_xfer_wait_end got=%b exp=%b", {sym_tick, busy, carrier_out}, {2'b11, ph});
        else
            n_pass++;
        @(negedge clk);
        n_chk++;
        if (carrier_out !== ph)
            $display("FAIL tick_xfer_first_preamble_flip got=%b exp=%b", carrier_out, ph);
        else
            n_pass++;
        found = -1;
        for (int c = 1; c <= 16 * SYM + 20; c++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                found = c;
                break;
            end
        end
        n_chk++;
        if (found != 16 * SYM)
            $display("FAIL tick_xfer_frame_done_delay got=%0d exp=%0d", found, 16 * SYM);
        else
            n_pass++;
    endtask

    // Reset during data bit 3, then a clean phase-0 carrier after release
    task automatic test_reset_mid_frame();
        int         ticks;
        logic [4:0] got5;
        logic [3:0] got, exp;
        while ((t % SYM) != 10) @(negedge clk);
        tx_if.tx_byte  = 8'hFF;
        tx_if.tx_valid = 1'b1;
        @(negedge clk);
        tx_if.tx_valid = 1'b0;
        ticks = 0;
        while (ticks < 1 + PRE + 3) begin
            if ((t % SYM) == SYM - 1) ticks++;
            @(negedge clk);
        end
        repeat (30) @(negedge clk);
        n_chk++;
        if (busy !== 1'b1)
            $display("FAIL rst_mid_busy_before got=%b exp=1", busy);
        else
            n_pass++;
        rst_n = 1'b0;
        #1;
        got5 = {carrier_out, sym_tick, busy, frame_done, tx_if.tx_ready};
        n_chk++;
        if (got5 !== 5'b10001)
            $display("FAIL rst_mid_immediate got=%b exp=10001", got5);
        else
            n_pass++;
        @(posedge clk);
        #1;
        got5 = {carrier_out, sym_tick, busy, frame_done, tx_if.tx_ready};
        n_chk++;
        if (got5 !== 5'b10001)
            $display("FAIL rst_mid_next_clk got=%b exp=10001", got5);
        else
            n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        ph = 1'b0;
        for (int i = 0; i < 2 * DIV + 5; i++) begin
            exp = {((i % DIV) < DIV / 2) ? 1'b1 : 1'b0, 1'b0, 1'b1, 1'b0};
            got = {carrier_out, busy, tx_if.tx_ready, frame_done};
            n_chk++;
            if (got !== exp)
                $display("FAIL rst_mid_restart cyc=%0d got=%b exp=%b", i, got, exp);
            else
                n_pass++;
            @(negedge clk);
        end
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        ph     = 1'b0;
        test_reset();
        test_idle();
        test_frame("zero", 1, 8'h00, 8'h00);
        test_frame("a5", 1, 8'hA5, 8'h00);
        test_frame("b2b", 2, 8'hFF, 8'h01);
        test_xfer_on_tick();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
